// File: rtl/delay_eye_scan_controller.sv
// Eye-scan sequencer for a cascaded input delay pair: sweeps all taps, finds the longest
// error-free run and loads its centre. Optional trace outputs under DELAY_EYE_SCAN_TRACE_EN.
module delay_eye_scan_controller #(
    parameter int unsigned MAX_TAP       = 511,
    parameter int unsigned SETTLE_CYCLES = 8,
    parameter int unsigned SAMPLE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       scan__start,
    input  logic       scan__abort,
    input  logic       manual__load,
    input  logic [8:0] manual__value,
    input  logic       data_sample,
    input  logic       expected,
    output logic       delay__load,
    output logic [8:0] delay__value,
    output logic       busy,
    output logic       result__valid,
    output logic       result__fail,
    output logic [8:0] result__tap,
    output logic [9:0] result__width
`ifdef DELAY_EYE_SCAN_TRACE_EN
    ,
    output logic       trace__valid,
    output logic [8:0] trace__tap,
    output logic       trace__good
`endif
);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StSettle,
        StSample,
        StStep,
        StCentre,
        StDone
    } state_e;

    state_e     state_q;
    logic [8:0] tap_q;
    logic [7:0] cnt_q;
    logic       tap_bad_q;
    logic [8:0] cur_start_q;
    logic [9:0] cur_len_q;
    logic [8:0] best_start_q;
    logic [9:0] best_len_q;
    logic       delay_load_q;
    logic [8:0] delay_value_q;
    logic       busy_q;
    logic       res_valid_q;
    logic       res_fail_q;
    logic [8:0] res_tap_q;
    logic [9:0] res_width_q;
`ifdef DELAY_EYE_SCAN_TRACE_EN
    logic       trace_valid_q;
    logic [8:0] trace_tap_q;
    logic       trace_good_q;
`endif

    logic       mismatch;
    logic       tap_good;
    logic [9:0] cur_len_ext;
    logic [8:0] step_cur_start;
    logic       best_upd;
    logic [9:0] step_best_len;
    logic [8:0] step_best_start;
    logic [8:0] step_centre;

    // Run-tracker values as they will be after the current STEP cycle.
    always_comb begin
        mismatch        = data_sample ^ expected;
        tap_good        = !tap_bad_q;
        cur_len_ext     = cur_len_q + 10'd1;
        step_cur_start  = (cur_len_q == 10'd0) ? tap_q : cur_start_q;
        best_upd        = tap_good && (cur_len_ext > best_len_q);
        step_best_len   = best_upd ? cur_len_ext : best_len_q;
        step_best_start = best_upd ? step_cur_start : best_start_q;
        step_centre     = (step_best_len == 10'd0) ? 9'd0 :
                          step_best_start + 9'((step_best_len - 10'd1) >> 1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= StIdle;
            tap_q         <= '0;
            cnt_q         <= '0;
            tap_bad_q     <= 1'b0;
            cur_start_q   <= '0;
            cur_len_q     <= '0;
            best_start_q  <= '0;
            best_len_q    <= '0;
            delay_load_q  <= 1'b0;
            delay_value_q <= '0;
            busy_q        <= 1'b0;
            res_valid_q   <= 1'b0;
            res_fail_q    <= 1'b0;
            res_tap_q     <= '0;
            res_width_q   <= '0;
`ifdef DELAY_EYE_SCAN_TRACE_EN
            trace_valid_q <= 1'b0;
            trace_tap_q   <= '0;
            trace_good_q  <= 1'b0;
`endif
        end else begin
            delay_load_q <= 1'b0;
            res_valid_q  <= 1'b0;
`ifdef DELAY_EYE_SCAN_TRACE_EN
            trace_valid_q <= 1'b0;
`endif
            if (scan__abort && state_q != StIdle) begin
                state_q <= StIdle;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    StIdle: begin
                        if (scan__start) begin
                            state_q       <= StLoad;
                            busy_q        <= 1'b1;
                            tap_q         <= '0;
                            cur_start_q   <= '0;
                            cur_len_q     <= '0;
                            best_start_q  <= '0;
                            best_len_q    <= '0;
                            delay_load_q  <= 1'b1;
                            delay_value_q <= '0;
                        end else if (manual__load) begin
                            delay_load_q  <= 1'b1;
                            delay_value_q <= manual__value;
                        end
                    end
                    StLoad: begin
                        state_q <= StSettle;
                        cnt_q   <= '0;
                    end
                    StSettle: begin
                        if (cnt_q == 8'(SETTLE_CYCLES - 1)) begin
                            state_q   <= StSample;
                            cnt_q     <= '0;
                            tap_bad_q <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q + 8'd1;
                        end
                    end
                    StSample: begin
                        tap_bad_q <= tap_bad_q | mismatch;
                        if (cnt_q == 8'(SAMPLE_CYCLES - 1)) begin
                            state_q <= StStep;
`ifdef DELAY_EYE_SCAN_TRACE_EN
                            trace_valid_q <= 1'b1;
                            trace_tap_q   <= tap_q;
                            trace_good_q  <= !(tap_bad_q | mismatch);
`endif
                        end else begin
                            cnt_q <= cnt_q + 8'd1;
                        end
                    end
                    StStep: begin
                        cur_len_q    <= tap_good ? cur_len_ext : 10'd0;
                        cur_start_q  <= step_cur_start;
                        best_len_q   <= step_best_len;
                        best_start_q <= step_best_start;
                        delay_load_q <= 1'b1;
                        if (tap_q == 9'(MAX_TAP)) begin
                            state_q       <= StCentre;
                            delay_value_q <= step_centre;
                        end else begin
                            state_q       <= StLoad;
                            tap_q         <= tap_q + 9'd1;
                            delay_value_q <= tap_q + 9'd1;
                        end
                    end
                    StCentre: begin
                        // delay_value_q already holds the centre tap being loaded now.
                        state_q     <= StDone;
                        res_valid_q <= 1'b1;
                        res_tap_q   <= delay_value_q;
                        res_width_q <= best_len_q;
                        res_fail_q  <= (best_len_q == 10'd0);
                    end
                    StDone: begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end
                    default: begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign delay__load   = delay_load_q;
    assign delay__value  = delay_value_q;
    assign busy          = busy_q;
    assign result__valid = res_valid_q;
    assign result__fail  = res_fail_q;
    assign result__tap   = res_tap_q;
    assign result__width = res_width_q;
`ifdef DELAY_EYE_SCAN_TRACE_EN
    assign trace__valid  = trace_valid_q;
    assign trace__tap    = trace_tap_q;
    assign trace__good   = trace_good_q;
`endif

endmodule

// File: tb/tb_delay_eye_scan_controller.sv
// Directed bench for delay_eye_scan_controller (MAX_TAP=15, SETTLE=2, SAMPLE=4) with a small
// delay-pair model that produces tap-dependent data.
module tb_delay_eye_scan_controller;

    localparam int unsigned MaxTap = 15;
    localparam int unsigned Settle = 2;
    localparam int unsigned Sample = 4;
    localparam int          ScanLat = (MaxTap + 1) * (1 + Settle + Sample + 1) + 2;

    logic       clk;
    logic       reset_n;
    logic       scan__start;
    logic       scan__abort;
    logic       manual__load;
    logic [8:0] manual__value;
    logic       data_sample;
    logic       expected;
    logic       delay__load;
    logic [8:0] delay__value;
    logic       busy;
    logic       result__valid;
    logic       result__fail;
    logic [8:0] result__tap;
    logic [9:0] result__width;
`ifdef DELAY_EYE_SCAN_TRACE_EN
    logic       trace__valid;
    logic [8:0] trace__tap;
    logic       trace__good;
`endif

    delay_eye_scan_controller #(
        .MAX_TAP      (MaxTap),
        .SETTLE_CYCLES(Settle),
        .SAMPLE_CYCLES(Sample)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .scan__start  (scan__start),
        .scan__abort  (scan__abort),
        .manual__load (manual__load),
        .manual__value(manual__value),
        .data_sample  (data_sample),
        .expected     (expected),
        .delay__load  (delay__load),
        .delay__value (delay__value),
        .busy         (busy),
        .result__valid(result__valid),
        .result__fail (result__fail),
        .result__tap  (result__tap),
        .result__width(result__width)
`ifdef DELAY_EYE_SCAN_TRACE_EN
        ,
        .trace__valid (trace__valid),
        .trace__tap   (trace__tap),
        .trace__good  (trace__good)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Delay-pair model: latches the loaded tap and counts cycles since the load.
    logic [15:0] good_mask;
    logic        inject;
    logic [8:0]  cur_tap;
    logic [7:0]  cyc;
    logic        bad;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cur_tap <= '0;
            cyc     <= '0;
        end else if (delay__load) begin
            cur_tap <= delay__value;
            cyc     <= '0;
        end else begin
            cyc <= cyc + 8'd1;
        end
    end

    // Garbage during settle (cyc 0..1); sampling window is cyc 2..5, last sample at cyc 5.
    always_comb begin
        expected    = cyc[0];
        bad         = (cyc < 8'd2) ||
                      !((cur_tap < 9'd16) ? good_mask[cur_tap[3:0]] : 1'b0) ||
                      (inject && cur_tap == 9'd5 && cyc == 8'd5);
        data_sample = expected ^ bad;
    end

    int n_checks;
    int n_fail;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic run_scan(input string tag, input logic [15:0] mask, input logic inj,
                            input logic [8:0] exp_tap, input logic [9:0] exp_width,
                            input logic exp_fail);
        logic [8:0] loads[$];
        int         lat;
        int         seq_err;
        logic [8:0] last_load;
        good_mask = mask;
        inject    = inj;
        lat       = 0;
        @(negedge clk);
        scan__start = 1'b1;
        for (int k = 1; k <= 400; k++) begin
            @(negedge clk);
            scan__start = 1'b0;
            if (delay__load) loads.push_back(delay__value);
            if (result__valid) begin
                lat = k;
                break;
            end
        end
        check_eq({tag, "/latency"}, lat, ScanLat);
        check_eq({tag, "/n_loads"}, loads.size(), MaxTap + 2);
        seq_err = 0;
        for (int i = 0; i <= int'(MaxTap); i++) begin
            if (i >= loads.size() || loads[i] != 9'(i)) seq_err++;
        end
        check_eq({tag, "/load_seq_err"}, seq_err, 0);
        last_load = (loads.size() > MaxTap + 1) ? loads[MaxTap + 1] : 9'h1ff;
        check_eq({tag, "/final_load"}, last_load, exp_tap);
        check_eq({tag, "/tap"}, result__tap, exp_tap);
        check_eq({tag, "/width"}, result__width, exp_width);
        check_eq({tag, "/fail"}, result__fail, exp_fail);
        @(negedge clk);
        check_eq({tag, "/valid_pulse"}, result__valid, 1'b0);
        check_eq({tag, "/busy_after"}, busy, 1'b0);
    endtask

    initial begin
        int n_loads;
        int n_valid;
        n_checks      = 0;
        n_fail        = 0;
        reset_n       = 1'b1;
        scan__start   = 1'b0;
        scan__abort   = 1'b0;
        manual__load  = 1'b0;
        manual__value = '0;
        good_mask     = '0;
        inject        = 1'b0;
        #3 reset_n = 1'b0;
        #1;
        check_eq("rst/delay_load", delay__load, 1'b0);
        check_eq("rst/delay_value", delay__value, 9'd0);
        check_eq("rst/busy", busy, 1'b0);
        check_eq("rst/result", {result__valid, result__fail, result__tap, result__width}, '0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // Manual load in IDLE
        @(negedge clk);
        manual__load  = 1'b1;
        manual__value = 9'h1A5;
        @(negedge clk);
        manual__load = 1'b0;
        check_eq("man/load", delay__load, 1'b1);
        check_eq("man/value", delay__value, 9'h1A5);
        check_eq("man/busy", busy, 1'b0);
        @(negedge clk);
        check_eq("man/load_off", delay__load, 1'b0);
        check_eq("man/value_held", delay__value, 9'h1A5);

        run_scan("scan_4_9", 16'h03F0, 1'b0, 9'd6, 10'd6, 1'b0);
        run_scan("scan_tie", 16'h070E, 1'b0, 9'd2, 10'd3, 1'b0);
        run_scan("scan_none", 16'h0000, 1'b0, 9'd0, 10'd0, 1'b1);
        run_scan("scan_inj", 16'h00F8, 1'b1, 9'd3, 10'd2, 1'b0);

        // Manual load during scan is ignored; abort during tap 7 SAMPLE
        good_mask = 16'hFFFF;
        inject    = 1'b0;
        n_loads   = 0;
        n_valid   = 0;
        @(negedge clk);
        scan__start = 1'b1;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            scan__start = 1'b0;
            if (k == 10) begin
                manual__load  = 1'b1;
                manual__value = 9'h1A5;
            end
            if (k == 11) begin
                manual__load = 1'b0;
                check_eq("busy_man/load", delay__load, 1'b0);
                check_eq("busy_man/value", delay__value, 9'd1);
            end
            if (k == 61) begin
                check_eq("abort/busy_before", busy, 1'b1);
                scan__abort = 1'b1;
            end
            if (k == 62) begin
                scan__abort = 1'b0;
                check_eq("abort/busy", busy, 1'b0);
                check_eq("abort/value", delay__value, 9'd7);
            end
            if (k >= 62) begin
                if (delay__load) n_loads++;
                if (result__valid) n_valid++;
            end
        end
        check_eq("abort/no_loads", n_loads, 0);
        check_eq("abort/no_valid", n_valid, 0);
        check_eq("abort/result_kept", {result__fail, result__tap, result__width},
                 {1'b0, 9'd3, 10'd2});

        // Start and manual load together: scan wins
        @(negedge clk);
        scan__start   = 1'b1;
        manual__load  = 1'b1;
        manual__value = 9'h1A5;
        @(negedge clk);
        scan__start  = 1'b0;
        manual__load = 1'b0;
        check_eq("both/load", delay__load, 1'b1);
        check_eq("both/value", delay__value, 9'd0);
        check_eq("both/busy", busy, 1'b1);

        // Reset mid-SETTLE of tap 1 (LOAD at cycle 9)
        repeat (9) @(negedge clk);
        check_eq("rst_mid/value_before", delay__value, 9'd1);
        #2 reset_n = 1'b0;
        #1;
        check_eq("rst_mid/busy", busy, 1'b0);
        check_eq("rst_mid/value", delay__value, 9'd0);
        check_eq("rst_mid/result", {result__valid, result__fail, result__tap, result__width}, '0);
        @(negedge clk);
        reset_n = 1'b1;

        // Reset during a LOAD cycle drops the strobe at once
        @(negedge clk);
        scan__start = 1'b1;
        @(negedge clk);
        scan__start = 1'b0;
        check_eq("rst_load/load_before", delay__load, 1'b1);
        #2 reset_n = 1'b0;
        #1;
        check_eq("rst_load/load", delay__load, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
